// File: rtl/frac_n_div_pkg.sv
// Shared constants and helpers for the fractional-N feedback divider.
package frac_n_div_pkg;

  // Smallest integer modulus the divider will run with.
  localparam int unsigned N_MIN = 32'd4;

  // Default integer modulus width and the matching modulus width.
  localparam int unsigned N_WIDTH_DEF   = 32'd9;
  localparam int unsigned MOD_WIDTH_DEF = N_WIDTH_DEF + 32'd1;

  // Modulus width for a given integer width: one extra bit holds n + carry.
  function automatic int unsigned mod_width(input int unsigned n_width);
    return n_width + 32'd1;
  endfunction

  // Number of high cycles of freq_out in a period of modulus m.
  function automatic int unsigned high_cycles(input int unsigned m);
    return m >> 1;
  endfunction

endpackage

// File: rtl/frac_n_accum.sv
// First-order fractional accumulator: adds the fractional word once per
// output period and reports the carry out of the FRAC_WIDTH-bit sum.
module frac_n_accum
  import frac_n_div_pkg::*;
#(
  parameter int FRAC_WIDTH = 16
) (
  input  logic                  freq_in,
  input  logic                  reset_n,
  input  logic                  i_step,
  input  logic [FRAC_WIDTH-1:0] i_frac,
  output logic                  o_carry
);

  logic [FRAC_WIDTH-1:0] r_acc;
  logic [FRAC_WIDTH:0]   w_sum;

  assign w_sum   = {1'b0, r_acc} + {1'b0, i_frac};
  assign o_carry = w_sum[FRAC_WIDTH];

  // Accumulator advances (wrapping) only on a period boundary.
  always_ff @(posedge freq_in or negedge reset_n) begin
    if (!reset_n) begin
      r_acc <= '0;
    end else if (i_step) begin
      r_acc <= w_sum[FRAC_WIDTH-1:0];
    end else begin
      r_acc <= r_acc;
    end
  end

endmodule

// File: rtl/frac_n_divider.sv
// Fractional-N feedback divider: divides freq_in by n_int + frac/2^FRAC_WIDTH
// on average. Configuration is shadowed and only applied on period boundaries.
module frac_n_divider
  import frac_n_div_pkg::*;
#(
  parameter int          N_WIDTH    = 9,
  parameter int          FRAC_WIDTH = 16,
  parameter int unsigned N_RST      = 248,
  parameter int unsigned F_RST      = 0
) (
  input  logic                  freq_in,
  input  logic                  reset_n,
  input  logic [N_WIDTH-1:0]    n_int,
  input  logic [FRAC_WIDTH-1:0] frac,
  input  logic                  load,
  output logic                  freq_out,
  output logic [N_WIDTH:0]      mod_out,
  output logic                  carry_out,
  output logic                  cfg_clamp
);

  localparam int MW = int'(mod_width(N_WIDTH));

  logic [MW-1:0]         r_count;
  logic [N_WIDTH-1:0]    r_n_act;
  logic [N_WIDTH-1:0]    r_n_sh;
  logic [FRAC_WIDTH-1:0] r_f_act;
  logic [FRAC_WIDTH-1:0] r_f_sh;
  logic                  r_pend;
  logic                  r_freq_out;
  logic [MW-1:0]         r_mod;
  logic                  r_carry;
  logic                  r_clamp;

  logic                  w_bnd;
  logic [N_WIDTH-1:0]    w_n_new;
  logic [FRAC_WIDTH-1:0] w_f_new;
  logic                  w_carry;
  logic                  w_clamp_new;
  logic [N_WIDTH-1:0]    w_n_eff;
  logic [MW-1:0]         w_mod_new;
  logic [MW-1:0]         w_count_nxt;
  logic [MW-1:0]         w_mod_nxt;
  logic [MW-1:0]         w_high;
  logic                  w_freq_nxt;

  // A boundary is the edge where the down-counter sits at zero.
  assign w_bnd = (r_count == '0);

  // Config that becomes active at this boundary (shadow if one is pending).
  assign w_n_new     = r_pend ? r_n_sh : r_n_act;
  assign w_f_new     = r_pend ? r_f_sh : r_f_act;
  assign w_clamp_new = (w_n_new < N_WIDTH'(N_MIN));
  assign w_n_eff     = w_clamp_new ? N_WIDTH'(N_MIN) : w_n_new;
  assign w_mod_new   = {1'b0, w_n_eff} + MW'(w_carry);

  frac_n_accum #(
    .FRAC_WIDTH (FRAC_WIDTH)
  ) u_accum (
    .freq_in (freq_in),
    .reset_n (reset_n),
    .i_step  (w_bnd),
    .i_frac  (w_f_new),
    .o_carry (w_carry)
  );

  // Next counter value and the modulus of the period that value belongs to.
  always_comb begin
    w_count_nxt = r_count;
    w_mod_nxt   = r_mod;
    if (w_bnd) begin
      w_count_nxt = w_mod_new - MW'(1'b1);
      w_mod_nxt   = w_mod_new;
    end else begin
      w_count_nxt = r_count - MW'(1'b1);
      w_mod_nxt   = r_mod;
    end
  end

  // Output is high for the first M>>1 counts of each period (count >= M-H).
  assign w_high     = MW'(high_cycles(32'(w_mod_nxt)));
  assign w_freq_nxt = (w_count_nxt >= (w_mod_nxt - w_high));

  // Shadow capture; a load always re-arms pend, even on a boundary edge.
  always_ff @(posedge freq_in or negedge reset_n) begin
    if (!reset_n) begin
      r_n_sh <= N_WIDTH'(N_RST);
      r_f_sh <= FRAC_WIDTH'(F_RST);
      r_pend <= 1'b0;
    end else if (load) begin
      r_n_sh <= n_int;
      r_f_sh <= frac;
      r_pend <= 1'b1;
    end else if (w_bnd) begin
      r_pend <= 1'b0;
    end else begin
      r_pend <= r_pend;
    end
  end

  // Active config takes the shadow only at a boundary with a pending load.
  always_ff @(posedge freq_in or negedge reset_n) begin
    if (!reset_n) begin
      r_n_act <= N_WIDTH'(N_RST);
      r_f_act <= FRAC_WIDTH'(F_RST);
    end else if (w_bnd && r_pend) begin
      r_n_act <= r_n_sh;
      r_f_act <= r_f_sh;
    end else begin
      r_n_act <= r_n_act;
      r_f_act <= r_f_act;
    end
  end

  // Counter, divided clock and per-period status registers.
  always_ff @(posedge freq_in or negedge reset_n) begin
    if (!reset_n) begin
      r_count    <= '0;
      r_freq_out <= 1'b0;
      r_mod      <= '0;
      r_carry    <= 1'b0;
      r_clamp    <= 1'b0;
    end else begin
      r_count    <= w_count_nxt;
      r_freq_out <= w_freq_nxt;
      r_mod      <= w_mod_nxt;
      if (w_bnd) begin
        r_carry <= w_carry;
        r_clamp <= w_clamp_new;
      end else begin
        r_carry <= r_carry;
        r_clamp <= r_clamp;
      end
    end
  end

  assign freq_out  = r_freq_out;
  assign mod_out   = r_mod;
  assign carry_out = r_carry;
  assign cfg_clamp = r_clamp;

endmodule

// File: tb/tb_frac_n_divider.sv
// Self-checking bench for frac_n_divider: a scoreboard of expected output
// periods is compared against periods measured on freq_out.
module tb_frac_n_divider;

  logic        freq_in = 1'b0;
  logic        reset_n = 1'b0;
  logic [8:0]  n_int   = 9'd0;
  logic [15:0] frac    = 16'd0;
  logic        load    = 1'b0;
  logic        freq_out;
  logic [9:0]  mod_out;
  logic        carry_out;
  logic        cfg_clamp;

  int n_checks = 0;
  int n_fail   = 0;
  int obs_sum  = 0;

  typedef struct {
    int len;
    int high;
    int mod;
    bit carry;
  } period_t;

  period_t exp_q[$];

  frac_n_divider dut (
    .freq_in   (freq_in),
    .reset_n   (reset_n),
    .n_int     (n_int),
    .frac      (frac),
    .load      (load),
    .freq_out  (freq_out),
    .mod_out   (mod_out),
    .carry_out (carry_out),
    .cfg_clamp (cfg_clamp)
  );

  always #5 freq_in = ~freq_in;

  // Period monitor: measures each freq_out period and scores it.
  bit have_prev = 1'b0;
  bit prev_out  = 1'b0;
  int cnt       = 0;
  int hcnt      = 0;
  int cur_mod   = 0;
  bit cur_carry = 1'b0;
  always @(negedge freq_in) begin
    if (!reset_n) begin
      have_prev = 1'b0;
      prev_out  = 1'b0;
    end else begin
      if (freq_out && !prev_out) begin
        if (have_prev) begin
          obs_sum += cnt;
          if (exp_q.size() > 0) begin
            period_t e;
            e = exp_q.pop_front();
            n_checks += 4;
            if (cnt !== e.len) begin
              n_fail++;
              $display("FAIL period_len got %0d want %0d", cnt, e.len);
            end
            if (hcnt !== e.high) begin
              n_fail++;
              $display("FAIL high_cycles got %0d want %0d", hcnt, e.high);
            end
            if (cur_mod !== e.mod) begin
              n_fail++;
              $display("FAIL mod_out got %0d want %0d", cur_mod, e.mod);
            end
            if (cur_carry !== e.carry) begin
              n_fail++;
              $display("FAIL carry_out got %0d want %0d (len %0d)", cur_carry, e.carry, e.len);
            end
          end
        end
        cnt       = 1;
        hcnt      = 1;
        cur_mod   = int'(mod_out);
        cur_carry = carry_out;
        have_prev = 1'b1;
      end else begin
        cnt++;
        if (freq_out) hcnt++;
      end
      prev_out = freq_out;
    end
  end

  task automatic push_exp(input int m, input bit c);
    period_t e;
    e.len   = m;
    e.high  = m / 2;
    e.mod   = m;
    e.carry = c;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input int budget, output bit tmo);
    tmo = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge freq_in);
      #1;
      if (exp_q.size() == 0) begin
        tmo = 1'b0;
        break;
      end
    end
  endtask

  task automatic do_load(input logic [8:0] n, input logic [15:0] f);
    @(negedge freq_in);
    n_int = n;
    frac  = f;
    load  = 1'b1;
    @(negedge freq_in);
    load  = 1'b0;
  endtask

  task automatic test_reset();
    bit tmo;
    reset_n = 1'b0;
    repeat (3) @(negedge freq_in);
    n_checks += 4;
    if (freq_out !== 1'b0) begin n_fail++; $display("FAIL rst_freq_out got %b want 0", freq_out); end
    if (mod_out !== 10'd0) begin n_fail++; $display("FAIL rst_mod_out got %0d want 0", mod_out); end
    if (carry_out !== 1'b0) begin n_fail++; $display("FAIL rst_carry got %b want 0", carry_out); end
    if (cfg_clamp !== 1'b0) begin n_fail++; $display("FAIL rst_clamp got %b want 0", cfg_clamp); end
    push_exp(248, 1'b0);
    push_exp(248, 1'b0);
    reset_n = 1'b1;
    @(negedge freq_in);
    n_checks++;
    if (freq_out !== 1'b1) begin n_fail++; $display("FAIL first_edge_rise got %b want 1", freq_out); end
    wait_drain(1000, tmo);
    n_checks++;
    if (tmo !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got %0d want 0 pending", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_load_mid();
    bit tmo;
    push_exp(248, 1'b0);
    for (int i = 0; i < 3; i++) push_exp(240, 1'b0);
    do_load(9'd240, 16'h0000);
    wait_drain(2000, tmo);
    n_checks++;
    if (tmo !== 1'b0) begin n_fail++; $display("FAIL load_mid_timeout got %0d want 0 pending", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_frac_half();
    bit tmo;
    int snap;
    push_exp(240, 1'b0);
    for (int i = 0; i < 16; i++) push_exp(240 + (i % 2), (i % 2) == 1);
    do_load(9'd240, 16'h8000);
    for (int i = 0; i < 1000; i++) begin
      @(negedge freq_in);
      #1;
      if (exp_q.size() <= 16) break;
    end
    snap = obs_sum;
    wait_drain(5000, tmo);
    n_checks += 2;
    if (tmo !== 1'b0) begin n_fail++; $display("FAIL half_timeout got %0d want 0 pending", exp_q.size()); exp_q.delete(); end
    if ((obs_sum - snap) !== 3848) begin n_fail++; $display("FAIL half_total got %0d want 3848", obs_sum - snap); end
  endtask

  task automatic test_frac_quarter();
    bit tmo;
    @(negedge freq_in);
    #2 reset_n = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge freq_in);
    reset_n = 1'b1;
    tmo = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge freq_in);
      if (freq_out) begin tmo = 1'b0; break; end
    end
    n_checks++;
    if (tmo !== 1'b0) begin n_fail++; $display("FAIL quarter_first_rise got %b want 1", freq_out); end
    n_int = 9'd240;
    frac  = 16'h4000;
    load  = 1'b1;
    push_exp(248, 1'b0);
    for (int i = 0; i < 8; i++) push_exp(((i % 4) == 3) ? 241 : 240, (i % 4) == 3);
    @(negedge freq_in);
    load = 1'b0;
    wait_drain(3000, tmo);
    n_checks++;
    if (tmo !== 1'b0) begin n_fail++; $display("FAIL quarter_timeout got %0d want 0 pending", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_clamp_and_boundary_load();
    bit tmo;
    push_exp(240, 1'b0);
    for (int i = 0; i < 3; i++) push_exp(4, 1'b0);
    do_load(9'd2, 16'h0000);
    wait_drain(1000, tmo);
    n_checks += 2;
    if (tmo !== 1'b0) begin n_fail++; $display("FAIL clamp_timeout got %0d want 0 pending", exp_q.size()); exp_q.delete(); end
    if (cfg_clamp !== 1'b1) begin n_fail++; $display("FAIL cfg_clamp_set got %b want 1", cfg_clamp); end
    // Here we are just after a boundary; the 4th following edge is the next one.
    push_exp(4, 1'b0);
    push_exp(4, 1'b0);
    push_exp(6, 1'b0);
    push_exp(6, 1'b0);
    repeat (3) @(negedge freq_in);
    n_int = 9'd6;
    frac  = 16'h0000;
    load  = 1'b1;
    @(negedge freq_in);
    load  = 1'b0;
    wait_drain(200, tmo);
    n_checks += 2;
    if (tmo !== 1'b0) begin n_fail++; $display("FAIL bnd_load_timeout got %0d want 0 pending", exp_q.size()); exp_q.delete(); end
    if (cfg_clamp !== 1'b0) begin n_fail++; $display("FAIL cfg_clamp_clear got %b want 0", cfg_clamp); end
  endtask

  task automatic test_reset_mid();
    bit tmo;
    push_exp(6, 1'b0);
    push_exp(240, 1'b0);
    do_load(9'd240, 16'h0000);
    wait_drain(1000, tmo);
    n_checks++;
    if (tmo !== 1'b0) begin n_fail++; $display("FAIL rmid_setup_timeout got %0d want 0 pending", exp_q.size()); exp_q.delete(); end
    repeat (40) @(negedge freq_in);
    do_load(9'd100, 16'h0000);
    repeat (10) @(negedge freq_in);
    n_checks++;
    if (freq_out !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_high got %b want 1", freq_out); end
    #3 reset_n = 1'b0;
    #1;
    n_checks += 3;
    if (freq_out !== 1'b0) begin n_fail++; $display("FAIL rmid_freq_out got %b want 0", freq_out); end
    if (mod_out !== 10'd0) begin n_fail++; $display("FAIL rmid_mod_out got %0d want 0", mod_out); end
    if (carry_out !== 1'b0) begin n_fail++; $display("FAIL rmid_carry got %b want 0", carry_out); end
    repeat (2) @(negedge freq_in);
    push_exp(248, 1'b0);
    push_exp(248, 1'b0);
    reset_n = 1'b1;
    wait_drain(1000, tmo);
    n_checks++;
    if (tmo !== 1'b0) begin n_fail++; $display("FAIL rmid_timeout got %0d want 0 pending", exp_q.size()); exp_q.delete(); end
  endtask

  initial begin
    test_reset();
    test_load_mid();
    test_frac_half();
    test_frac_quarter();
    test_clamp_and_boundary_load();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/frac_n_divider.md
# frac_n_divider

Parametrised fractional-N feedback divider for the PLL loop, successor to the fixed 240/248 dual-modulus divider. Divides `freq_in` by a programmable integer modulus `n_int` plus a first-order accumulator carry, giving an average ratio of n_int + frac/2^FRAC_WIDTH. Sits between the VCO prescaler output and the phase-frequency detector. Configuration is shadowed and applied only on output-period boundaries.

## Interface
- `N_WIDTH`, default 9: width of the integer modulus.
- `FRAC_WIDTH`, default 16: accumulator and fractional word width.
- `N_RST`, default 248: integer modulus loaded by reset.
- `F_RST`, default 0: fractional word loaded by reset.
- `freq_in`  in  1: divider clock, rising edge; the single clock of the block.
- `reset_n`  in  1: asynchronous, active-low reset.
- `n_int`  in  N_WIDTH: requested integer modulus.
- `frac`  in  FRAC_WIDTH: requested fractional word.
- `load`  in  1: single-cycle strobe that captures `n_int`/`frac` into the shadow registers.
- `freq_out`  out  1: divided clock, registered.
- `mod_out`  out  N_WIDTH+1: modulus of the current output period.
- `carry_out`  out  1: accumulator carry used for the current period.
- `cfg_clamp`  out  1: high while the active `n_int` is below N_MIN and has been clamped.

## Operation
- Registers: down-counter `count` (N_WIDTH+1 bits), accumulator `acc` (FRAC_WIDTH bits), active config `n_act`/`f_act`, shadow config `n_sh`/`f_sh`, flag `pend`.
- `load`=1: `n_sh`<=`n_int`, `f_sh`<=`frac`, `pend`<=1. A later `load` before the boundary overwrites the shadow; the last value wins.
- A boundary occurs on every edge where `count`==0. At a boundary:
  - If `pend`=1, `n_act`/`f_act`<=shadow and `pend`<=0. A `load` coincident with a boundary is not applied at that boundary; it waits for the next one.
  - {carry, acc} <= acc + f (FRAC_WIDTH+1-bit sum), where f is the newly active fractional word.
  - M = max(n, N_MIN) + carry, where n is the newly active integer word. `count`<=M-1. `mod_out`<=M. `carry_out`<=carry.
- Otherwise `count` decrements by 1.
- H = M>>1. `freq_out`=1 while `count` is in [M-H, M-1], i.e. for H cycles; it is 0 for the remaining M-H cycles.
- Examples: M=240 gives 120 high / 120 low; M=241 gives 120 high / 121 low.
- Clamp: `n_int` below N_MIN=4 is clamped to 4 when it becomes active. `cfg_clamp` reflects the active config.
- Maximum modulus is 2^N_WIDTH, reached with n=2^N_WIDTH-1 and carry=1; `mod_out` is sized for it.

## Timing
- Reset values:
  - `freq_out`=0, `count`=0, `acc`=0, `pend`=0, `mod_out`=0, `carry_out`=0, `cfg_clamp`=0.
  - `n_act`/`n_sh`=N_RST, `f_act`/`f_sh`=F_RST.
- The first rising edge of `freq_in` after `reset_n` deasserts is a boundary, so `freq_out` rises on that edge.
- Rising edge to rising edge of `freq_out` is exactly M `freq_in` cycles.
- Config latency: a `load` affects the first boundary strictly after the load edge; no mid-period modulus change ever occurs.
- Reset mid-period: all outputs clear immediately, asynchronously. Any pending `load` is discarded and the reset defaults are restored.
- `acc` wraps modulo 2^FRAC_WIDTH. `frac`=0 gives pure integer division with `carry_out`=0 in every period.

## Structure
- Package `frac_n_div_pkg` holds:
  - the constant N_MIN=4;
  - the function `high_cycles(M)`=M>>1;
  - the localparam for the modulus width (N_WIDTH+1).
- Sub-module `frac_n_accum`: the FRAC_WIDTH accumulator with a step enable (the boundary) and a carry output.
- Top level `frac_n_divider` holds the shadow/active registers, the counter, and `freq_out` generation.

## Test plan
- Reset defaults at a 10 ns clock, no `load` -> `freq_out` period 2480 ns (248 cycles), 124 high; `mod_out`=248, `carry_out`=0.
- `load` with n_int=240, frac=0 mid-period -> the current period completes at 248, then every period is 240 cycles with 120 high.
- n_int=240, frac=0x8000 -> periods alternate 240, 241, starting with 240; 16 consecutive periods total 3848 cycles.
- n_int=240, frac=0x4000 -> repeating pattern 240, 240, 240, 241; `carry_out` is high only in every 4th period.
- n_int=2 -> `mod_out`=4, `cfg_clamp`=1, 2 cycles high / 2 low. `load` coincident with a boundary -> new config takes effect one period later.
- `reset_n` pulsed low mid-period with n=240 active -> `freq_out`=0 immediately; after release, periods are 248 again.
